axi_lite_cmd_master: RTL

//  AXI4-Lite initiator that turns single-beat commands from a local engine into AXI4-Lite read/write transactions against a slave peripheral such as the CAN controller.

---
 rtl/axi_lite_cmd_master.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/axi_lite_cmd_master.sv
// -----------------------------------------------------------------------------
// axi_lite_cmd_master
//
// AXI4-Lite initiator that turns single-beat commands from a local engine into
// AXI4-Lite read or write transactions. Only one transaction is in flight at a
// time, and every accepted command produces exactly one response pulse.
//
// Ports
//   M_AXI_ACLK / M_AXI_ARESET   clock, synchronous active-high reset
//   CMD_*                       command side: valid/ready, read-not-write,
//                               byte offset, write data, write strobes
//   RSP_*                       one-cycle completion pulse with read data
//                               (0 for writes) and the slave's BRESP/RRESP
//   M_AXI_AW* / W* / B*         AXI4-Lite write address, data and response
//   M_AXI_AR* / R*              AXI4-Lite read address and data
// -----------------------------------------------------------------------------
module axi_lite_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASEADDR = 32'h72400000
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,

    input  logic                              CMD_VALID,
    output logic                              CMD_READY,
    input  logic                              CMD_RNW,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   CMD_WSTRB,

    output logic                              RSP_VALID,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     RSP_RDATA,
    output logic [1:0]                        RSP_RESP,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        DONE
    } state_t;

    state_t                              state;
    logic [C_M_AXI_ADDR_WIDTH-1:0]       addr_q;

    // A single latched address serves both channels; only one of AWVALID or
    // ARVALID is ever raised for a given command.
    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;

    // Whole transaction sequencer. Every output is a register so nothing
    // combinationally depends on the slave's READY/VALID inputs.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state         <= IDLE;
            CMD_READY     <= 1'b0;
            RSP_VALID     <= 1'b0;
            RSP_RDATA     <= '0;
            RSP_RESP      <= 2'b00;
            addr_q        <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // CMD_READY comes up one cycle after entering IDLE from reset.
                    if (CMD_VALID && CMD_READY) begin
                        CMD_READY <= 1'b0;
                        // Base + offset wraps naturally at the address width.
                        addr_q    <= C_BASEADDR + CMD_ADDR;
                        if (CMD_RNW) begin
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_AR;
                        end else begin
                            M_AXI_WDATA   <= CMD_WDATA;
                            M_AXI_WSTRB   <= CMD_WSTRB;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WR_AW_W;
                        end
                    end else begin
                        CMD_READY <= 1'b1;
                    end
                end

                WR_AW_W: begin
                    // Each channel retires on its own handshake; a low VALID
                    // here means that channel has already completed.
                    if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                    end
                    if (M_AXI_WVALID && M_AXI_WREADY) begin
                        M_AXI_WVALID <= 1'b0;
                    end
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) &&
                        (!M_AXI_WVALID  || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_B;
                    end
                end

                WR_B: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        RSP_RESP     <= M_AXI_BRESP;
                        RSP_RDATA    <= '0;
                        RSP_VALID    <= 1'b1;
                        state        <= DONE;
                    end
                end

                RD_AR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_R;
                    end
                end

                RD_R: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        RSP_RESP     <= M_AXI_RRESP;
                        RSP_RDATA    <= M_AXI_RDATA;
                        RSP_VALID    <= 1'b1;
                        state        <= DONE;
                    end
                end

                DONE: begin
                    // Response fields stay put until the next completion.
                    RSP_VALID <= 1'b0;
                    CMD_READY <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
